vga_timing_sequencer_n: RTL

- Parametrised microcoded video-timing generator: runs a small uploaded program that drives vsync/hsync/visible/start-of-frame and a pixel enable.
- Generalises the fixed 2-counter, divide-by-2 sequencer:
  - N counters, configurable counter width and program depth.
  - Runtime pixel-clock divider.
  - Directly addressed program load.
  - NOP/HALT opcodes, frame counter and sticky program-error flag.
- Sits between the frame-buffer DMA/pixel FIFO and the VGA pins.

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/sram_1r1w.sv | 29 ++
 rtl/vga_pixel_divider.sv | 35 +++
 rtl/vga_timing_sequencer_n.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared opcode, micro-op layout and field positions for the microcoded VGA timing sequencer.
package vga_timing_pkg;

    localparam int DEF_NUM_COUNTERS     = 4;
    localparam int DEF_COUNTER_WIDTH    = 13;
    localparam int DEF_MAX_INSTRUCTIONS = 64;
    localparam int DEF_DIV_WIDTH        = 4;

    localparam int CSEL_W = $clog2(DEF_NUM_COUNTERS);
    localparam int UOP_W  = 2 + CSEL_W + DEF_COUNTER_WIDTH + 4;

    // Bit positions for software that assembles program words, LSB upward.
    localparam int VISIBLE_BIT    = 0;
    localparam int FRAME_DONE_BIT = 1;
    localparam int HSYNC_BIT      = 2;
    localparam int VSYNC_BIT      = 3;
    localparam int IMM_LSB        = 4;
    localparam int CSEL_LSB       = IMM_LSB + DEF_COUNTER_WIDTH;
    localparam int OPCODE_LSB     = CSEL_LSB + CSEL_W;

    typedef enum logic [1:0] {
        OP_INITCNT = 2'b00,
        OP_LOOP    = 2'b01,
        OP_NOP     = 2'b10,
        OP_HALT    = 2'b11
    } opcode_e;

    typedef struct packed {
        opcode_e                      opcode;
        logic [CSEL_W-1:0]            csel;
        logic [DEF_COUNTER_WIDTH-1:0] imm;
        logic                         vsync;
        logic                         hsync;
        logic                         frame_done;
        logic                         visible;
    } uop_t;

endpackage

// File: rtl/sram_1r1w.sv
// Simple dual-port RAM: one synchronous write port, one registered read port with write-first bypass.
module sram_1r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE       = 64,
    parameter int ADDR_W     = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [SIZE];

    // A same-cycle write to the read address is forwarded so the reader never sees a stale word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_o <= wdata_i;
        end else begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/vga_pixel_divider.sv
// Runtime clock divider producing a one-clk pixel enable every pixel_div+1 clocks.
module vga_pixel_divider #(
    parameter int DIV_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_i,
    input  logic [DIV_WIDTH-1:0] pixel_div_i,
    output logic                 pixel_en_o
);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_d;
    logic                 wrap;

    // Using >= lets a shrunken pixel_div take effect without waiting for the counter to overflow.
    assign wrap       = (div_q >= pixel_div_i);
    assign pixel_en_o = enable_i & wrap;

    always_comb begin
        div_d = div_q + DIV_WIDTH'(1);
        if (!enable_i || wrap) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/vga_timing_sequencer_n.sv
// Microcoded VGA timing sequencer: executes an uploaded uop program once per pixel period.
module vga_timing_sequencer_n
    import vga_timing_pkg::*;
#(
    parameter int NUM_COUNTERS     = DEF_NUM_COUNTERS,
    parameter int COUNTER_WIDTH    = DEF_COUNTER_WIDTH,
    parameter int MAX_INSTRUCTIONS = DEF_MAX_INSTRUCTIONS,
    parameter int DIV_WIDTH        = DEF_DIV_WIDTH
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                sequencer_en,
    input  logic [DIV_WIDTH-1:0]                pixel_div,
    input  logic                                prog_write_en,
    input  logic [$clog2(MAX_INSTRUCTIONS)-1:0] prog_addr,
    input  logic [31:0]                         prog_data,
    output logic                                vga_vs,
    output logic                                vga_hs,
    output logic                                in_visible_region,
    output logic                                start_frame,
    output logic                                pixel_en,
    output logic [15:0]                         frame_count,
    output logic                                prog_error
);

    localparam int PC_W = $clog2(MAX_INSTRUCTIONS);
    localparam int CSW  = $clog2(NUM_COUNTERS);
    localparam int UW   = 2 + CSW + COUNTER_WIDTH + 4;

    logic                     active;
    logic                     pixelEn;
    logic [UW-1:0]            uopWord;
    logic                     progWe;
    logic                     unusedProgBits;

    opcode_e                  op;
    logic [CSW-1:0]           csel;
    logic [COUNTER_WIDTH-1:0] imm;
    logic                     uopVs;
    logic                     uopHs;
    logic                     uopFrameDone;
    logic                     uopVisible;

    logic [PC_W-1:0]          pc_q, pc_d;
    logic [COUNTER_WIDTH-1:0] cnt_q [NUM_COUNTERS];
    logic [COUNTER_WIDTH-1:0] cnt_d [NUM_COUNTERS];
    logic                     halted_q, halted_d;
    logic [15:0]              frameCount_q, frameCount_d;
    logic                     progError_q, progError_d;

    logic [PC_W-1:0]          pcInc;
    logic [COUNTER_WIDTH-1:0] loopNext;
    logic                     redirect;

    // Reset also gates the outputs so nothing toggles while reset_n is held low.
    assign active = sequencer_en & reset_n;
    assign progWe = prog_write_en & ~sequencer_en;
    assign unusedProgBits = ^prog_data[31:UW];

    vga_pixel_divider #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_divider (
        .clk         (clk),
        .rst_n       (reset_n),
        .enable_i    (active),
        .pixel_div_i (pixel_div),
        .pixel_en_o  (pixelEn)
    );

    // Read address is the next pc, so the registered word always belongs to the current pc.
    sram_1r1w #(
        .DATA_WIDTH (UW),
        .SIZE       (MAX_INSTRUCTIONS)
    ) u_prog_mem (
        .clk     (clk),
        .we_i    (progWe),
        .waddr_i (prog_addr),
        .wdata_i (prog_data[UW-1:0]),
        .raddr_i (pc_d),
        .rdata_o (uopWord)
    );

    assign op           = opcode_e'(uopWord[UW-1 -: 2]);
    assign csel         = uopWord[UW-3 -: CSW];
    assign imm          = uopWord[4 +: COUNTER_WIDTH];
    assign uopVs        = uopWord[3];
    assign uopHs        = uopWord[2];
    assign uopFrameDone = uopWord[1];
    assign uopVisible   = uopWord[0];

    assign pcInc    = (pc_q == PC_W'(MAX_INSTRUCTIONS - 1)) ? '0 : pc_q + PC_W'(1);
    assign loopNext = cnt_q[csel] - COUNTER_WIDTH'(1);

    always_comb begin
        pc_d         = pc_q;
        cnt_d        = cnt_q;
        halted_d     = halted_q;
        frameCount_d = frameCount_q;
        progError_d  = progError_q;
        redirect     = 1'b0;

        if (!active) begin
            pc_d     = '0;
            cnt_d    = '{default: '0};
            halted_d = 1'b0;
        end else if (pixelEn && !halted_q) begin
            unique case (op)
                OP_INITCNT: begin
                    cnt_d[csel] = imm;
                    pc_d        = pcInc;
                end
                OP_LOOP: begin
                    cnt_d[csel] = loopNext;
                    if (loopNext != '0) begin
                        redirect = 1'b1;
                    end else begin
                        pc_d = pcInc;
                    end
                end
                OP_NOP: begin
                    pc_d = pcInc;
                end
                OP_HALT: begin
                    halted_d = 1'b1;
                end
            endcase

            if (uopFrameDone) begin
                redirect     = 1'b1;
                frameCount_d = frameCount_q + 16'd1;
            end

            // A target past the end of program memory restarts the program and latches the error.
            if (redirect) begin
                if (imm >= COUNTER_WIDTH'(MAX_INSTRUCTIONS)) begin
                    pc_d        = '0;
                    progError_d = 1'b1;
                end else begin
                    pc_d = PC_W'(imm);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q         <= '0;
            halted_q     <= 1'b0;
            frameCount_q <= '0;
            progError_q  <= 1'b0;
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pc_q         <= pc_d;
            halted_q     <= halted_d;
            frameCount_q <= frameCount_d;
            progError_q  <= progError_d;
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign vga_vs            = active & uopVs;
    assign vga_hs            = active & uopHs;
    assign in_visible_region = active & uopVisible;
    assign start_frame       = active & (pc_q == '0);
    assign pixel_en          = pixelEn;
    assign frame_count       = frameCount_q;
    assign prog_error        = progError_q;

endmodule
